// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types. The draw stages import this package too,
// so the default 800x600@60 numbers live here and nowhere else.
package vga_pkg;

    localparam int COUNT_W   = 11;
    localparam int MAX_TOTAL = 2048;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BACK    = 88;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
        logic frame_start;
    } timing_flags_t;

    // Half-open window test [lo, hi) done in int so thresholds up to 2048 stay exact.
    function automatic logic in_window(input count_t value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to the draw stages.
interface vga_timing_gen_if
    import vga_pkg::*;
;
    count_t hcount_out;
    count_t vcount_out;
    logic   hsync_out;
    logic   vsync_out;
    logic   hblnk_out;
    logic   vblnk_out;
    logic   frame_start;

    modport master (
        output hcount_out, vcount_out, hsync_out, vsync_out,
               hblnk_out, vblnk_out, frame_start
    );

    modport slave (
        input hcount_out, vcount_out, hsync_out, vsync_out,
              hblnk_out, vblnk_out, frame_start
    );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MODULUS counter; exposes its next value so callers can register decodes
// that stay aligned with the count itself.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MODULUS = DEF_H_TOTAL
) (
    input  logic   pclk,
    input  logic   rst,
    input  logic   en,
    output count_t count,
    output count_t count_next,
    output logic   wrap
);

    localparam count_t LAST = count_t'(MODULUS - 1);

    always_comb begin
        count_next = count;
        wrap       = 1'b0;
        if (en) begin
            if (count == LAST) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count + count_t'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters plus registered blank, sync and
// frame-start flags decoded from the next counts so every output changes together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b1
) (
    input logic              pclk,
    input logic              rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam timing_flags_t FLAGS_RESET = '{
        hsync:       !SYNC_POL,
        vsync:       !SYNC_POL,
        hblnk:       1'b0,
        vblnk:       1'b0,
        frame_start: 1'b0
    };

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_params
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
        end
    endgenerate

    count_t        hcount;
    count_t        vcount;
    count_t        h_next;
    count_t        v_next;
    logic          h_wrap;
    logic          v_wrap;
    timing_flags_t flags_d;
    timing_flags_t flags_q;

    wrap_counter #(.MODULUS(H_TOTAL)) u_h_counter (
        .pclk       (pclk),
        .rst        (rst),
        .en         (1'b1),
        .count      (hcount),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(.MODULUS(V_TOTAL)) u_v_counter (
        .pclk       (pclk),
        .rst        (rst),
        .en         (h_wrap),
        .count      (vcount),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // v_wrap only fires together with h_wrap, i.e. exactly on the (last,last) -> (0,0) step.
    always_comb begin
        flags_d             = FLAGS_RESET;
        flags_d.hblnk       = int'(h_next) >= H_VISIBLE;
        flags_d.vblnk       = int'(v_next) >= V_VISIBLE;
        flags_d.hsync       = in_window(h_next, HS_START, HS_END) ? SYNC_POL : !SYNC_POL;
        flags_d.vsync       = in_window(v_next, VS_START, VS_END) ? SYNC_POL : !SYNC_POL;
        flags_d.frame_start = v_wrap;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            flags_q <= FLAGS_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign vga.hcount_out  = hcount;
    assign vga.vcount_out  = vcount;
    assign vga.hsync_out   = flags_q.hsync;
    assign vga.vsync_out   = flags_q.vsync;
    assign vga.hblnk_out   = flags_q.hblnk;
    assign vga.vblnk_out   = flags_q.vblnk;
    assign vga.frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 instance plus two reduced 14x7 instances
// (both sync polarities), checked every cycle against an elapsed-cycle raster model.
module tb_vga_timing_gen;

    localparam int S_FRAME = 14 * 7;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic hb;
        logic vb;
        logic fs;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst  = 1'b0;
    int unsigned n    = 0;
    int          total  = 0;
    int          passed = 0;

    bit track_line = 1'b0;
    int hs_cycles  = 0;
    int hs_first   = -1;
    int hb_cycles  = 0;
    int hb_first   = -1;
    int fs_seen    = 0;
    int fs_expect  = 0;

    vga_timing_gen_if def_if ();
    vga_timing_gen_if small_if ();
    vga_timing_gen_if small_n_if ();

    vga_timing_gen dut_def (
        .pclk (pclk),
        .rst  (rst),
        .vga  (def_if)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) dut_small (
        .pclk (pclk),
        .rst  (rst),
        .vga  (small_if)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) dut_small_n (
        .pclk (pclk),
        .rst  (rst),
        .vga  (small_n_if)
    );

    always #5 pclk = ~pclk;

    // Raster position after n pixel clocks since reset release, straight from the timing rules.
    function automatic exp_t model(input int unsigned cycles,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb,
                                   input bit pol);
        exp_t e;
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        e.h  = int'(cycles % ht);
        e.v  = int'((cycles / ht) % vt);
        e.hb = (e.h >= hv);
        e.vb = (e.v >= vv);
        e.hs = (e.h >= hv + hf && e.h < hv + hf + hs) ? pol : !pol;
        e.vs = (e.v >= vv + vf && e.v < vv + vf + vs) ? pol : !pol;
        e.fs = (cycles > 0) && (e.h == 0) && (e.v == 0);
        return e;
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s (cycle %0d): observed %0d expected %0d", tag, n, obs, exp);
    endtask

    task automatic check_one(input string name, input exp_t e,
                             input logic [10:0] h, input logic [10:0] v,
                             input logic hs, input logic vs, input logic hb,
                             input logic vb, input logic fs);
        compare({name, ".hcount"}, h, e.h);
        compare({name, ".vcount"}, v, e.v);
        compare({name, ".hsync"}, hs, e.hs);
        compare({name, ".vsync"}, vs, e.vs);
        compare({name, ".hblnk"}, hb, e.hb);
        compare({name, ".vblnk"}, vb, e.vb);
        compare({name, ".frame_start"}, fs, e.fs);
    endtask

    task automatic check_output();
        exp_t e_def;
        exp_t e_small;
        exp_t e_small_n;
        e_def     = model(n, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1);
        e_small   = model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1);
        e_small_n = model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0);
        check_one("def", e_def, def_if.hcount_out, def_if.vcount_out, def_if.hsync_out,
                  def_if.vsync_out, def_if.hblnk_out, def_if.vblnk_out, def_if.frame_start);
        check_one("small", e_small, small_if.hcount_out, small_if.vcount_out, small_if.hsync_out,
                  small_if.vsync_out, small_if.hblnk_out, small_if.vblnk_out, small_if.frame_start);
        check_one("small_n", e_small_n, small_n_if.hcount_out, small_n_if.vcount_out,
                  small_n_if.hsync_out, small_n_if.vsync_out, small_n_if.hblnk_out,
                  small_n_if.vblnk_out, small_n_if.frame_start);
    endtask

    task automatic run_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge pclk);
            if (rst) n++;
            @(negedge pclk);
            check_output();
            if (small_if.frame_start === 1'b1) fs_seen++;
            if (n > 0 && (n % S_FRAME) == 0) fs_expect++;
            if (track_line && n >= 1 && n <= 1056) begin
                if (def_if.hsync_out === 1'b1) begin
                    hs_cycles++;
                    if (hs_first < 0) hs_first = int'(def_if.hcount_out);
                end
                if (def_if.hblnk_out === 1'b1) begin
                    hb_cycles++;
                    if (hb_first < 0) hb_first = int'(def_if.hcount_out);
                end
            end
        end
    endtask

    // Asynchronous reset between clock edges; outputs must already be at reset values.
    task automatic apply_async_reset(input int delay);
        #(delay);
        rst = 1'b0;
        n   = 0;
        #1;
        check_output();
        @(negedge pclk);
        check_output();
        rst = 1'b1;
    endtask

    initial begin
        bit found;

        $display("[TB] reset state");
        repeat (3) @(negedge pclk);
        check_output();

        $display("[TB] two default lines after release");
        rst        = 1'b1;
        n          = 0;
        track_line = 1'b1;
        run_cycles(2 * 1056 + 4);
        track_line = 1'b0;
        compare("line.hsync_cycles", hs_cycles, 128);
        compare("line.hsync_first", hs_first, 840);
        compare("line.hblnk_cycles", hb_cycles, 256);
        compare("line.hblnk_first", hb_first, 800);

        $display("[TB] reset inside the reduced vsync/hsync window");
        found = 1'b0;
        for (int i = 0; i < 4 * S_FRAME && !found; i++) begin
            if (small_if.hcount_out == 11'd10 && small_if.vcount_out == 11'd5)
                found = 1'b1;
            else
                run_cycles(1);
        end
        compare("wait.sync_window", found, 1'b1);
        apply_async_reset(2);
        run_cycles(3 * S_FRAME + 20);

        $display("[TB] randomized reset points");
        for (int k = 0; k < 4; k++) begin
            run_cycles(int'($urandom_range(1, 300)));
            apply_async_reset(int'($urandom_range(1, 3)));
        end
        run_cycles(2 * S_FRAME + 5);

        compare("small.frame_start_count", fs_seen, fs_expect);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 800: visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 40: horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128: hsync width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 88: horizontal back porch in pixels; H_TOTAL = sum of the four, 1056 by default.
REQ-005 The block SHALL have parameter V_VISIBLE, default 600: visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 1: vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 4: vsync width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 23: vertical back porch in lines; V_TOTAL = 628 by default.
REQ-009 The block SHALL have parameter SYNC_POL, default 1: active level of hsync_out and vsync_out.
REQ-010 Port: pclk  input  1  pixel clock, 40 MHz for defaults; single clock domain.
REQ-011 Port: rst  input  1  asynchronous, active-low reset.
REQ-012 Port: hcount_out  output  11  current pixel column.
REQ-013 Port: vcount_out  output  11  current line.
REQ-014 Port: hsync_out  output  1  horizontal sync at SYNC_POL level when active.
REQ-015 Port: vsync_out  output  1  vertical sync at SYNC_POL level when active.
REQ-016 Port: hblnk_out  output  1  high outside the visible columns.
REQ-017 Port: vblnk_out  output  1  high outside the visible lines.
REQ-018 Port: frame_start  output  1  one-cycle pulse on the first pixel of each frame.

Function
REQ-019 hcount_out SHALL increment by 1 every pclk cycle and wrap from H_TOTAL-1 to 0.
REQ-020 vcount_out SHALL increment by 1 only in the cycle hcount_out wraps, and SHALL wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-021 hblnk_out SHALL be high exactly when hcount_out >= H_VISIBLE (800..1055 by default).
REQ-022 vblnk_out SHALL be high exactly when vcount_out >= V_VISIBLE (600..627).
REQ-023 hsync_out SHALL be active exactly when H_VISIBLE+H_FRONT <= hcount_out < H_VISIBLE+H_FRONT+H_SYNC (840..967).
REQ-024 vsync_out SHALL be active exactly when V_VISIBLE+V_FRONT <= vcount_out < V_VISIBLE+V_FRONT+V_SYNC (601..604).
REQ-025 All outputs SHALL be registered; the blank, sync and pulse signals SHALL be decoded from next-state counts so that they are cycle-aligned with the counts they describe, with zero skew between outputs.
REQ-026 frame_start SHALL be high for exactly one cycle, namely the cycle in which the counts change from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-027 Counter arithmetic SHALL be 11-bit unsigned; counts SHALL never reach H_TOTAL or V_TOTAL.
REQ-028 Parameter sets with H_TOTAL > 2048 or V_TOTAL > 2048 SHALL be rejected at elaboration.

Reset
REQ-029 While rst is low, the block SHALL drive hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, frame_start=0, and hsync_out=vsync_out=!SYNC_POL.
REQ-030 Reset SHALL take effect asynchronously, including mid-line and mid-sync.
REQ-031 After reset release, the first pclk edge SHALL advance hcount_out to 1.
REQ-032 frame_start SHALL NOT pulse for the frame that begins at reset release.

Structure
REQ-033 The default timing constants (H_/V_ values and totals for 800x600@60) SHALL reside in a shared package vga_pkg that the draw stages also import.
REQ-034 The horizontal and vertical counters SHALL each be an instance of one sub-module, wrap_counter (parameterised modulus, count-enable in, wrap pulse out).

Verification
REQ-035 Release reset and run 1056 cycles -> hcount_out sequences 0..1055 then 0; vcount_out steps from 0 to 1 at the wrap.
REQ-036 Run a full line -> hsync_out is active for exactly 128 cycles starting at hcount_out=840; hblnk_out is high for exactly 256 cycles starting at hcount_out=800.
REQ-037 Run 2 full frames (2 x 663168 cycles) -> vsync_out is active on lines 601..604 only; vblnk_out is high on lines 600..627; frame_start pulses exactly once per frame at (0,0), with no pulse at reset release.
REQ-038 Assert rst at hcount_out=900, vcount_out=602 -> all outputs take their reset values immediately, with no wait for a clock edge; after release, counting restarts from 0,0.
REQ-039 Set SYNC_POL=0 -> sync outputs are inverted relative to SYNC_POL=1 and idle high during reset.
REQ-040 Use a reduced parameter set (H 8/2/2/2, V 4/1/1/1) -> H_TOTAL=14 and V_TOTAL=7 wrap correctly, and all decode boundaries match REQ-021..REQ-026.
